// File: rtl/gb_bus_dma.sv
// CPU-side bus front end for the DMG: decodes HRAM and the OAM DMA register,
// runs the OAM DMA engine and locks the CPU off the system bus while it copies.
module gb_bus_dma #(
  parameter int          DMA_LENGTH    = 160,
  parameter logic [15:0] DMA_DEST_BASE = 16'hFE00,
  parameter logic [15:0] DMA_REG_ADDR  = 16'hFF46
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpuAddress,
  input  logic [7:0]  cpuDataW,
  input  logic        cpuRW,
  output logic [7:0]  cpuDataR,
  output logic [15:0] memAddress,
  output logic [7:0]  memDataW,
  input  logic [7:0]  memDataR,
  output logic        memWE,
  output logic        dmaActive
);

  typedef enum logic [1:0] {IDLE, DMA_START, DMA_READ, DMA_WRITE} state_t;
  typedef enum logic [1:0] {SRC_LOCAL, SRC_MEM, SRC_FF} src_t;

  localparam logic [7:0] LAST_IDX = 8'(DMA_LENGTH - 1);

  state_t      state_q, state_d;
  logic [7:0]  counter_q, counter_d;
  logic [7:0]  dma_reg_q, dma_reg_d;
  src_t        sel_q, sel_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic [7:0]  cpu_data_r_q, cpu_data_r_d;

  // Slot 127 would be FFFF, which belongs to the system bus and is never written.
  logic [7:0]  hram [0:127];

  logic is_hram, is_dma_reg, is_sys, bus_locked;

  assign is_hram    = (cpuAddress[15:7] == 9'h1FF) && (cpuAddress[6:0] != 7'h7F);
  assign is_dma_reg = (cpuAddress == DMA_REG_ADDR);
  assign is_sys     = !is_hram && !is_dma_reg;
  assign bus_locked = (state_q == DMA_READ) || (state_q == DMA_WRITE);

  assign dmaActive  = (state_q != IDLE);
  assign cpuDataR   = cpu_data_r_q;

  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    dma_reg_d  = dma_reg_q;
    memAddress = cpuAddress;
    memDataW   = cpuDataW;
    memWE      = cpuRW && is_sys;

    case (state_q)
      IDLE: ;
      DMA_START: state_d = DMA_READ;
      DMA_READ: begin
        memAddress = {dma_reg_q, counter_q};
        memDataW   = 8'h00;
        memWE      = 1'b0;
        state_d    = DMA_WRITE;
      end
      DMA_WRITE: begin
        memAddress = DMA_DEST_BASE + {8'h00, counter_q};
        memDataW   = memDataR;
        memWE      = 1'b1;
        if (counter_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          counter_d = counter_q + 8'd1;
          state_d   = DMA_READ;
        end
      end
      default: state_d = IDLE;
    endcase

    // A register write restarts the engine, overriding the final-byte return to IDLE.
    if (cpuRW && is_dma_reg) begin
      dma_reg_d = cpuDataW;
      counter_d = 8'h00;
      state_d   = DMA_START;
    end

    if (reset) begin
      memAddress = 16'h0000;
      memDataW   = 8'h00;
      memWE      = 1'b0;
    end
  end

  always_comb begin
    rd_data_d = is_hram ? hram[cpuAddress[6:0]] : dma_reg_q;
    if (is_hram || is_dma_reg) begin
      sel_d = SRC_LOCAL;
    end else if (bus_locked) begin
      sel_d = SRC_FF;
    end else begin
      sel_d = SRC_MEM;
    end

    // Second read stage: memory data only becomes valid one cycle after its address.
    case (sel_q)
      SRC_LOCAL: cpu_data_r_d = rd_data_q;
      SRC_MEM:   cpu_data_r_d = memDataR;
      default:   cpu_data_r_d = 8'hFF;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      counter_q    <= 8'h00;
      dma_reg_q    <= 8'h00;
      sel_q        <= SRC_FF;
      rd_data_q    <= 8'hFF;
      cpu_data_r_q <= 8'hFF;
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      dma_reg_q    <= dma_reg_d;
      sel_q        <= sel_d;
      rd_data_q    <= rd_data_d;
      cpu_data_r_q <= cpu_data_r_d;
    end
  end

  always_ff @(posedge clk) begin
    if (cpuRW && is_hram) begin
      hram[cpuAddress[6:0]] <= cpuDataW;
    end
  end

endmodule

// File: tb/tb_gb_bus_dma.sv
// Testbench for gb_bus_dma: system memory model plus scenario tasks checked
// against expectations derived from DMA timing and copy rules.
module tb_gb_bus_dma;

  localparam logic [15:0] DMA_REG = 16'hFF46;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpuAddress;
  logic [7:0]  cpuDataW;
  logic        cpuRW;
  logic [7:0]  cpuDataR;
  logic [15:0] memAddress;
  logic [7:0]  memDataW;
  logic [7:0]  memDataR;
  logic        memWE;
  logic        dmaActive;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] mem      [0:65535];
  logic [7:0] hram_ref [0:127];
  logic [7:0] src_data [0:3][0:159];

  gb_bus_dma dut (
    .clk        (clk),
    .reset      (reset),
    .cpuAddress (cpuAddress),
    .cpuDataW   (cpuDataW),
    .cpuRW      (cpuRW),
    .cpuDataR   (cpuDataR),
    .memAddress (memAddress),
    .memDataW   (memDataW),
    .memDataR   (memDataR),
    .memWE      (memWE),
    .dmaActive  (dmaActive)
  );

  always #5 clk = ~clk;

  // Synchronous system memory: read data is valid the cycle after the address.
  always @(posedge clk) begin
    memDataR <= mem[memAddress];
    if (memWE) mem[memAddress] <= memDataW;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic rw);
    @(negedge clk);
    cpuAddress = a;
    cpuDataW   = d;
    cpuRW      = rw;
    #1;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
    drive(a, 8'h00, 1'b0);
    drive(16'h0000, 8'h00, 1'b0);
    drive(16'h0000, 8'h00, 1'b0);
    d = cpuDataR;
  endtask

  task automatic preload(input int slot, input logic [7:0] page, input bit pattern);
    logic [7:0] v;
    for (int i = 0; i < 160; i++) begin
      v = pattern ? (8'(i) ^ 8'hA5) : 8'($urandom);
      src_data[slot][i] = v;
      drive({page, 8'(i)}, v, 1'b1);
    end
  endtask

  // Counts cycles with dmaActive high and OAM writes, starting the cycle after the call.
  task automatic monitor_dma(output int active, output int writes);
    active = 0;
    writes = 0;
    for (int c = 0; c < 1000; c++) begin
      drive(16'h0000, 8'h00, 1'b0);
      if (!dmaActive) break;
      active++;
      if (memWE && memAddress >= 16'hFE00 && memAddress < 16'hFEA0) writes++;
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    reset = 1'b1; cpuAddress = 16'h0000; cpuDataW = 8'h00; cpuRW = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    compared++; if (cpuDataR !== 8'hFF) begin mismatched++; $display("[TB] FAIL reset_cpuDataR got=%h exp=ff", cpuDataR); end
    compared++; if (memWE !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_memWE got=%b exp=0", memWE); end
    compared++; if (dmaActive !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_dmaActive got=%b exp=0", dmaActive); end
    compared++; if (memAddress !== 16'h0000) begin mismatched++; $display("[TB] FAIL reset_memAddress got=%h exp=0000", memAddress); end
    compared++; if (memDataW !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_memDataW got=%h exp=00", memDataW); end
    @(negedge clk);
    reset = 1'b0;
    cpu_read(DMA_REG, d);
    compared++; if (d !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_dmaReg got=%h exp=00", d); end
  endtask

  task automatic test_pass_through();
    logic [15:0] a;
    logic [7:0]  v, r;
    drive(16'hC123, 8'h5A, 1'b1);
    compared++; if (memWE !== 1'b1) begin mismatched++; $display("[TB] FAIL pass_memWE got=%b exp=1", memWE); end
    compared++; if (memAddress !== 16'hC123) begin mismatched++; $display("[TB] FAIL pass_memAddress got=%h exp=c123", memAddress); end
    compared++; if (memDataW !== 8'h5A) begin mismatched++; $display("[TB] FAIL pass_memDataW got=%h exp=5a", memDataW); end
    cpu_read(16'hC123, r);
    compared++; if (r !== 8'h5A) begin mismatched++; $display("[TB] FAIL pass_read got=%h exp=5a", r); end
    for (int k = 0; k < 4; k++) begin
      a = 16'hD000 + 16'($urandom_range(0, 4095));
      v = 8'($urandom);
      drive(a, v, 1'b1);
      compared++; if (memWE !== 1'b1 || memAddress !== a) begin mismatched++; $display("[TB] FAIL pass_rand_write got=%b/%h exp=1/%h", memWE, memAddress, a); end
      cpu_read(a, r);
      compared++; if (r !== v) begin mismatched++; $display("[TB] FAIL pass_rand_read addr=%h got=%h exp=%h", a, r, v); end
    end
    v = 8'($urandom);
    drive(16'hFFFF, v, 1'b1);
    compared++; if (memWE !== 1'b1) begin mismatched++; $display("[TB] FAIL pass_ffff_memWE got=%b exp=1", memWE); end
    cpu_read(16'hFFFF, r);
    compared++; if (r !== v) begin mismatched++; $display("[TB] FAIL pass_ffff_read got=%h exp=%h", r, v); end
    drive(16'hFF7F, 8'h11, 1'b1);
    compared++; if (memWE !== 1'b1) begin mismatched++; $display("[TB] FAIL pass_ff7f_memWE got=%b exp=1", memWE); end
  endtask

  task automatic test_hram();
    logic [15:0] addrs [0:6];
    logic [7:0]  v, r;
    drive(16'hFF90, 8'h3C, 1'b1);
    compared++; if (memWE !== 1'b0) begin mismatched++; $display("[TB] FAIL hram_memWE got=%b exp=0", memWE); end
    hram_ref[7'h10] = 8'h3C;
    cpu_read(16'hFF90, r);
    compared++; if (r !== 8'h3C) begin mismatched++; $display("[TB] FAIL hram_ff90 got=%h exp=3c", r); end
    addrs[0] = 16'hFF80;
    addrs[1] = 16'hFFFE;
    for (int k = 2; k < 7; k++) addrs[k] = 16'hFF80 + 16'($urandom_range(0, 126));
    for (int k = 0; k < 7; k++) begin
      v = 8'($urandom);
      hram_ref[addrs[k][6:0]] = v;
      drive(addrs[k], v, 1'b1);
      compared++; if (memWE !== 1'b0) begin mismatched++; $display("[TB] FAIL hram_rand_memWE addr=%h got=%b exp=0", addrs[k], memWE); end
    end
    for (int k = 0; k < 7; k++) begin
      cpu_read(addrs[k], r);
      compared++; if (r !== hram_ref[addrs[k][6:0]]) begin mismatched++; $display("[TB] FAIL hram_rand_read addr=%h got=%h exp=%h", addrs[k], r, hram_ref[addrs[k][6:0]]); end
    end
  endtask

  task automatic run_dma_check(input string name, input int slot, input logic [7:0] page);
    int active, writes, bad;
    logic [7:0] r;
    drive(DMA_REG, page, 1'b1);
    monitor_dma(active, writes);
    compared++; if (active !== 321) begin mismatched++; $display("[TB] FAIL %s_active got=%0d exp=321", name, active); end
    compared++; if (writes !== 160) begin mismatched++; $display("[TB] FAIL %s_writes got=%0d exp=160", name, writes); end
    bad = 0;
    for (int i = 0; i < 160; i++) if (mem[16'hFE00 + 16'(i)] !== src_data[slot][i]) bad++;
    compared++; if (bad !== 0) begin mismatched++; $display("[TB] FAIL %s_oam got=%0d_bad_bytes exp=0", name, bad); end
    cpu_read(DMA_REG, r);
    compared++; if (r !== page) begin mismatched++; $display("[TB] FAIL %s_dmaReg got=%h exp=%h", name, r, page); end
  endtask

  task automatic test_full_dma();
    preload(0, 8'hC0, 1'b1);
    run_dma_check("full", 0, 8'hC0);
  endtask

  task automatic test_random_dma();
    logic [7:0] page;
    page = 8'hD0 + 8'($urandom_range(0, 15));
    preload(3, page, 1'b0);
    run_dma_check("rand", 3, page);
  endtask

  task automatic test_lockout();
    int active, writes;
    logic [7:0] v, r;
    v = 8'($urandom);
    drive(DMA_REG, 8'hC0, 1'b1);
    drive(16'h0000, 8'h00, 1'b0);
    drive(16'h0000, 8'h00, 1'b0);
    drive(16'hC000, 8'h00, 1'b0);
    drive(16'hC000, 8'h77, 1'b1);
    compared++; if (memWE === 1'b1 && memAddress === 16'hC000) begin mismatched++; $display("[TB] FAIL lock_write got=we_at_c000 exp=dropped"); end
    drive(16'hFF80, v, 1'b1);
    compared++; if (cpuDataR !== 8'hFF) begin mismatched++; $display("[TB] FAIL lock_read got=%h exp=ff", cpuDataR); end
    cpu_read(16'hFF80, r);
    compared++; if (r !== v) begin mismatched++; $display("[TB] FAIL lock_hram got=%h exp=%h", r, v); end
    monitor_dma(active, writes);
    compared++; if (active !== 313) begin mismatched++; $display("[TB] FAIL lock_remaining got=%0d exp=313", active); end
    compared++; if (mem[16'hC000] !== 8'hA5) begin mismatched++; $display("[TB] FAIL lock_c000 got=%h exp=a5", mem[16'hC000]); end
  endtask

  task automatic test_restart();
    int n, active, writes, bad;
    preload(1, 8'hC1, 1'b0);
    drive(DMA_REG, 8'hC0, 1'b1);
    n = 0;
    for (int c = 0; c < 400; c++) begin
      drive(16'h0000, 8'h00, 1'b0);
      if (memWE && memAddress >= 16'hFE00 && memAddress < 16'hFEA0) n++;
      if (n == 50) break;
    end
    compared++; if (n !== 50) begin mismatched++; $display("[TB] FAIL restart_reach50 got=%0d exp=50", n); end
    drive(DMA_REG, 8'hC1, 1'b1);
    compared++; if (memWE !== 1'b0 || dmaActive !== 1'b1) begin mismatched++; $display("[TB] FAIL restart_midread got=%b/%b exp=0/1", memWE, dmaActive); end
    monitor_dma(active, writes);
    compared++; if (active !== 321) begin mismatched++; $display("[TB] FAIL restart_active got=%0d exp=321", active); end
    compared++; if (writes !== 160) begin mismatched++; $display("[TB] FAIL restart_writes got=%0d exp=160", writes); end
    compared++; if (mem[16'hFE00] !== src_data[1][0]) begin mismatched++; $display("[TB] FAIL restart_fe00 got=%h exp=%h", mem[16'hFE00], src_data[1][0]); end
    bad = 0;
    for (int i = 0; i < 160; i++) if (mem[16'hFE00 + 16'(i)] !== src_data[1][i]) bad++;
    compared++; if (bad !== 0) begin mismatched++; $display("[TB] FAIL restart_oam got=%0d_bad_bytes exp=0", bad); end
  endtask

  task automatic test_back_to_back();
    int active, writes, bad;
    preload(2, 8'hC2, 1'b0);
    drive(DMA_REG, 8'hC1, 1'b1);
    repeat (320) drive(16'h0000, 8'h00, 1'b0);
    drive(DMA_REG, 8'hC2, 1'b1);
    compared++; if (memWE !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_last_memWE got=%b exp=1", memWE); end
    compared++; if (memAddress !== 16'hFE9F) begin mismatched++; $display("[TB] FAIL b2b_last_addr got=%h exp=fe9f", memAddress); end
    compared++; if (memDataW !== src_data[1][159]) begin mismatched++; $display("[TB] FAIL b2b_last_data got=%h exp=%h", memDataW, src_data[1][159]); end
    monitor_dma(active, writes);
    compared++; if (active !== 321) begin mismatched++; $display("[TB] FAIL b2b_active got=%0d exp=321", active); end
    compared++; if (writes !== 160) begin mismatched++; $display("[TB] FAIL b2b_writes got=%0d exp=160", writes); end
    bad = 0;
    for (int i = 0; i < 160; i++) if (mem[16'hFE00 + 16'(i)] !== src_data[2][i]) bad++;
    compared++; if (bad !== 0) begin mismatched++; $display("[TB] FAIL b2b_oam got=%0d_bad_bytes exp=0", bad); end
  endtask

  task automatic test_reset_mid_dma();
    bit found;
    logic [7:0] r;
    drive(DMA_REG, 8'hC2, 1'b1);
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      drive(16'h0000, 8'h00, 1'b0);
      if (memWE) begin found = 1'b1; break; end
    end
    compared++; if (found !== 1'b1) begin mismatched++; $display("[TB] FAIL rstmid_find_write got=0 exp=1"); end
    reset = 1'b1;
    #1;
    compared++; if (memWE !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_memWE got=%b exp=0", memWE); end
    compared++; if (dmaActive !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_dmaActive got=%b exp=0", dmaActive); end
    compared++; if (cpuDataR !== 8'hFF) begin mismatched++; $display("[TB] FAIL rstmid_cpuDataR got=%h exp=ff", cpuDataR); end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) drive(16'h0000, 8'h00, 1'b0);
    compared++; if (dmaActive !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_stays_idle got=%b exp=0", dmaActive); end
    cpu_read(DMA_REG, r);
    compared++; if (r !== 8'h00) begin mismatched++; $display("[TB] FAIL rstmid_dmaReg got=%h exp=00", r); end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_hram();
    test_full_dma();
    test_random_dma();
    test_lockout();
    test_restart();
    test_back_to_back();
    test_reset_mid_dma();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
